ysyx_23060124_wbu: RTL and testbench

//  Write-back stage between EXU/LSU and the register file. Takes one retiring

---
 rtl/ysyx_23060124_wbu_pkg.sv | 23 ++
 rtl/ysyx_23060124_wbu_if.sv | 31 +++
 rtl/ysyx_23060124_load_ext.sv | 50 +++++
 rtl/ysyx_23060124_wbu.sv | 140 ++++++++++++++
 tb/tb_ysyx_23060124_wbu.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060124_wbu_pkg.sv
// Shared definitions for the write-back unit: default widths, FSM state
// encoding, RISC-V load funct3 codes and the OKAY response code.
package ysyx_23060124_wbu_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int RF_AW_DEF  = 4;
  localparam int PERF_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_COMMIT    = 2'd2
  } wbu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_23060124_wbu_if.sv
// EXU -> WBU retire handshake plus the LSU read-data return path.
// master: EXU/LSU side (drives instruction and load data).
// slave : WBU side (drives exu_ready).
interface ysyx_23060124_wbu_if #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 4
);
  logic             exu_valid;
  logic             exu_ready;
  logic [RF_AW-1:0] exu_rd;
  logic             exu_wen;
  logic             exu_is_load;
  logic [2:0]       exu_funct3;
  logic [1:0]       exu_addr_lo;
  logic [XLEN-1:0]  exu_result;
  logic             lsu_rvalid;
  logic [XLEN-1:0]  lsu_rdata;
  logic [1:0]       lsu_rresp;

  modport master (
    output exu_valid, exu_rd, exu_wen, exu_is_load, exu_funct3, exu_addr_lo,
           exu_result, lsu_rvalid, lsu_rdata, lsu_rresp,
    input  exu_ready
  );

  modport slave (
    input  exu_valid, exu_rd, exu_wen, exu_is_load, exu_funct3, exu_addr_lo,
           exu_result, lsu_rvalid, lsu_rdata, lsu_rresp,
    output exu_ready
  );
endinterface

// File: rtl/ysyx_23060124_load_ext.sv
// Combinational load-data extractor: selects the byte/half addressed by
// addr_lo from an aligned word and sign- or zero-extends it per funct3.
// A halfword at offset 3 and any undefined funct3 pass the word through.
module ysyx_23060124_load_ext
  import ysyx_23060124_wbu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the raw word.
  always_comb begin
    byte_s = rdata[7:0];
    half_s = rdata[15:0];
    case (addr_lo)
      2'd0: begin byte_s = rdata[7:0];   half_s = rdata[15:0];  end
      2'd1: begin byte_s = rdata[15:8];  half_s = rdata[23:8];  end
      2'd2: begin byte_s = rdata[23:16]; half_s = rdata[31:16]; end
      2'd3: begin byte_s = rdata[31:24]; half_s = rdata[15:0];  end
      default: begin byte_s = rdata[7:0]; half_s = rdata[15:0]; end
    endcase
  end

  // Extend the selected field according to the load type.
  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_s};
      F3_LH: begin
        if (addr_lo == 2'd3) data = rdata;
        else                 data = {{(XLEN-16){half_s[15]}}, half_s};
      end
      F3_LHU: begin
        if (addr_lo == 2'd3) data = rdata;
        else                 data = {{(XLEN-16){1'b0}}, half_s};
      end
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060124_wbu.sv
// Write-back stage: accepts one retiring instruction per EXU handshake,
// waits for load data when needed, and pulses the register-file write port
// for one cycle in COMMIT. Also publishes the in-flight destination for the
// decode-stage hazard check.
// Optional feature: define YSYX_23060124_WBU_PERF_CNT_EN to add the
// perf_retired / perf_load_stall counters.
module ysyx_23060124_wbu
  import ysyx_23060124_wbu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int RF_AW  = RF_AW_DEF
`ifdef YSYX_23060124_WBU_PERF_CNT_EN
  , parameter int PERF_W = PERF_W_DEF
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  ysyx_23060124_wbu_if.slave    bus,
  output logic                  rf_wen,
  output logic [RF_AW-1:0]      rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [RF_AW-1:0]      wbu_rd,
  output logic [XLEN-1:0]       wbu_wdata,
  output logic                  retire,
  output logic                  load_fault
`ifdef YSYX_23060124_WBU_PERF_CNT_EN
  , output logic [PERF_W-1:0]   perf_retired
  , output logic [PERF_W-1:0]   perf_load_stall
`endif
);

  wbu_state_e       state_r, state_nxt;
  logic [RF_AW-1:0] rd_r;
  logic             wen_r;
  logic [2:0]       funct3_r;
  logic [1:0]       addr_lo_r;
  logic [XLEN-1:0]  data_r;
  logic             load_fault_r;

  logic             ready_s;
  logic             accept_s;
  logic             commit_s;
  logic             rd_live_s;
  logic             load_done_s;
  logic [XLEN-1:0]  ext_data_s;

  ysyx_23060124_load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3  (funct3_r),
    .addr_lo (addr_lo_r),
    .rdata   (bus.lsu_rdata),
    .data    (ext_data_s)
  );

  assign bus.exu_ready = ready_s;

  // State register; an async reset abandons any in-flight instruction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_nxt;
  end

  // Next-state selection and the outputs derived from the latched instruction.
  always_comb begin
    state_nxt   = state_r;
    ready_s     = (state_r == ST_IDLE) || (state_r == ST_COMMIT);
    accept_s    = bus.exu_valid && ready_s;
    load_done_s = (state_r == ST_WAIT_LOAD) && bus.lsu_rvalid;
    commit_s    = (state_r == ST_COMMIT);
    rd_live_s   = (state_r != ST_IDLE) && wen_r && (rd_r != '0);

    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt = bus.exu_is_load ? ST_WAIT_LOAD : ST_COMMIT;
        else          state_nxt = ST_IDLE;
      end
      ST_WAIT_LOAD: begin
        if (bus.lsu_rvalid) state_nxt = ST_COMMIT;
        else                state_nxt = ST_WAIT_LOAD;
      end
      ST_COMMIT: begin
        if (accept_s) state_nxt = bus.exu_is_load ? ST_WAIT_LOAD : ST_COMMIT;
        else          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    rf_wen     = commit_s && wen_r && (rd_r != '0);
    rf_waddr   = commit_s ? rd_r : '0;
    rf_wdata   = commit_s ? data_r : '0;
    retire     = commit_s;
    wbu_rd     = rd_live_s ? rd_r : '0;
    wbu_wdata  = rd_live_s ? data_r : '0;
    load_fault = load_fault_r;
  end

  // Instruction latch: capture on accept, fill in load data on return.
  // A faulting load keeps its slot but loses its write enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_r      <= '0;
      wen_r     <= 1'b0;
      funct3_r  <= 3'b000;
      addr_lo_r <= 2'b00;
      data_r    <= '0;
    end else if (accept_s) begin
      rd_r      <= bus.exu_rd;
      wen_r     <= bus.exu_wen;
      funct3_r  <= bus.exu_funct3;
      addr_lo_r <= bus.exu_addr_lo;
      data_r    <= bus.exu_is_load ? '0 : bus.exu_result;
    end else if (load_done_s) begin
      if (bus.lsu_rresp != RESP_OKAY) wen_r  <= 1'b0;
      else                            data_r <= ext_data_s;
    end else begin
      data_r <= data_r;
    end
  end

  // Sticky load-error flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                        load_fault_r <= 1'b0;
    else if (load_done_s && (bus.lsu_rresp != RESP_OKAY)) load_fault_r <= 1'b1;
    else                                               load_fault_r <= load_fault_r;
  end

`ifdef YSYX_23060124_WBU_PERF_CNT_EN
  // Retire and load-stall counters, wrapping at their natural width.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_retired    <= '0;
      perf_load_stall <= '0;
    end else begin
      if (commit_s) perf_retired <= perf_retired + {{(PERF_W-1){1'b0}}, 1'b1};
      if (state_r == ST_WAIT_LOAD)
        perf_load_stall <= perf_load_stall + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060124_wbu.sv
// Self-checking bench for ysyx_23060124_wbu: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the write-back stage.
module tb_ysyx_23060124_wbu;

  logic        clock = 1'b0;
  logic        reset;
  logic        rf_wen;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  wbu_rd;
  logic [31:0] wbu_wdata;
  logic        retire;
  logic        load_fault;
`ifdef YSYX_23060124_WBU_PERF_CNT_EN
  logic [63:0] perf_retired;
  logic [63:0] perf_load_stall;
`endif

  always #5 clock = ~clock;

  ysyx_23060124_wbu_if bus ();

  ysyx_23060124_wbu dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .wbu_rd     (wbu_rd),
    .wbu_wdata  (wbu_wdata),
    .retire     (retire),
    .load_fault (load_fault)
`ifdef YSYX_23060124_WBU_PERF_CNT_EN
    , .perf_retired    (perf_retired)
    , .perf_load_stall (perf_load_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: one held instruction (m_pend), possibly still awaiting its data.
  bit          m_pend, m_wait, m_fault, m_wen;
  logic [3:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_lo;
  logic [31:0] m_data;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] rdata);
    int unsigned w, b, h, sh;
    w  = rdata;
    sh = 8 * int'(lo);
    b  = (w >> sh) & 32'd255;
    h  = (w >> sh) & 32'd65535;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (lo == 2'd3) ? w : ((h >= 32'd32768) ? (h + 32'hFFFF_0000) : h);
      3'd5:    return (lo == 2'd3) ? w : h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit          commit, live;
    commit = m_pend && !m_wait;
    live   = m_pend && m_wen && (m_rd != 4'd0);
    chk("exu_ready",  {31'd0, bus.exu_ready}, {31'd0, !(m_pend && m_wait)});
    chk("rf_wen",     {31'd0, rf_wen},        {31'd0, commit && m_wen && (m_rd != 4'd0)});
    chk("rf_waddr",   {28'd0, rf_waddr},      commit ? {28'd0, m_rd} : 32'd0);
    chk("rf_wdata",   rf_wdata,               commit ? m_data : 32'd0);
    chk("wbu_rd",     {28'd0, wbu_rd},        live ? {28'd0, m_rd} : 32'd0);
    chk("wbu_wdata",  wbu_wdata,              live ? m_data : 32'd0);
    chk("retire",     {31'd0, retire},        {31'd0, commit});
    chk("load_fault", {31'd0, load_fault},    {31'd0, m_fault});
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_wait = 1'b0; m_fault = 1'b0; m_wen = 1'b0;
    m_rd = 4'd0; m_f3 = 3'd0; m_lo = 2'd0; m_data = 32'd0;
  endtask

  // Advance the model by one clock using the inputs currently driven, then
  // step the DUT and compare on the falling edge.
  task automatic tick();
    bit          n_pend, n_wait, n_fault, n_wen;
    logic [3:0]  n_rd;
    logic [2:0]  n_f3;
    logic [1:0]  n_lo;
    logic [31:0] n_data;
    n_pend = m_pend; n_wait = m_wait; n_fault = m_fault; n_wen = m_wen;
    n_rd = m_rd; n_f3 = m_f3; n_lo = m_lo; n_data = m_data;
    if (m_pend && m_wait) begin
      if (bus.lsu_rvalid) begin
        n_wait = 1'b0;
        if (bus.lsu_rresp != 2'b00) begin
          n_fault = 1'b1;
          n_wen   = 1'b0;
        end else begin
          n_data = ref_load(m_f3, m_lo, bus.lsu_rdata);
        end
      end
    end else if (bus.exu_valid) begin
      n_pend = 1'b1;
      n_wait = bus.exu_is_load;
      n_rd   = bus.exu_rd;
      n_wen  = bus.exu_wen;
      n_f3   = bus.exu_funct3;
      n_lo   = bus.exu_addr_lo;
      n_data = bus.exu_is_load ? 32'd0 : bus.exu_result;
    end else begin
      n_pend = 1'b0;
      n_wait = 1'b0;
    end
    @(posedge clock);
    m_pend = n_pend; m_wait = n_wait; m_fault = n_fault; m_wen = n_wen;
    m_rd = n_rd; m_f3 = n_f3; m_lo = n_lo; m_data = n_data;
    @(negedge clock);
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [3:0] rd, input bit wen, input bit ld,
                       input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] res);
    bus.exu_valid = v; bus.exu_rd = rd; bus.exu_wen = wen; bus.exu_is_load = ld;
    bus.exu_funct3 = f3; bus.exu_addr_lo = lo; bus.exu_result = res;
  endtask

  task automatic lsu(input bit v, input logic [31:0] d, input logic [1:0] r);
    bus.lsu_rvalid = v; bus.lsu_rdata = d; bus.lsu_rresp = r;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    lsu(1'b0, 32'd0, 2'd0);
    model_reset();
    repeat (2) @(negedge clock);
    compare_all();
    chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    reset = 1'b1;

    // 1: single ALU op
    drive(1'b1, 4'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_1234);
    tick();
    chk("t1_rf_wen", {31'd0, rf_wen}, 32'd1);
    chk("t1_waddr", {28'd0, rf_waddr}, 32'd5);
    chk("t1_wdata", rf_wdata, 32'h0000_1234);
    chk("t1_retire", {31'd0, retire}, 32'd1);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    tick();

    // 2: lb at offset 2 with stalls
    drive(1'b1, 4'd7, 1'b1, 1'b1, 3'd0, 2'd2, 32'hAAAA_AAAA);
    tick();
    chk("t2_wbu_rd", {28'd0, wbu_rd}, 32'd7);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_rd", {28'd0, wbu_rd}, 32'd7);
      chk("t2_stall_ready", {31'd0, bus.exu_ready}, 32'd0);
    end
    lsu(1'b1, 32'h0080_0000, 2'd0);
    tick();
    lsu(1'b0, 32'd0, 2'd0);
    chk("t2_wdata", rf_wdata, 32'hFFFF_FF80);
    chk("t2_rf_wen", {31'd0, rf_wen}, 32'd1);
    tick();

    // 3: lhu to x0
    drive(1'b1, 4'd0, 1'b1, 1'b1, 3'd5, 2'd2, 32'd0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    lsu(1'b1, 32'hBEEF_0000, 2'd0);
    tick();
    lsu(1'b0, 32'd0, 2'd0);
    chk("t3_wdata", rf_wdata, 32'h0000_BEEF);
    chk("t3_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("t3_retire", {31'd0, retire}, 32'd1);
    tick();

    // 4: three back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i + 1), 1'b1, 1'b0, 3'd0, 2'd0, 32'h100 + 32'(i));
      tick();
      chk("t4_ready", {31'd0, bus.exu_ready}, 32'd1);
      chk("t4_rf_wen", {31'd0, rf_wen}, 32'd1);
      chk("t4_waddr", {28'd0, rf_waddr}, 32'(i + 1));
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    tick();

    // 5: faulting load
    drive(1'b1, 4'd9, 1'b1, 1'b1, 3'd2, 2'd0, 32'd0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    lsu(1'b1, 32'hDEAD_BEEF, 2'd2);
    tick();
    lsu(1'b0, 32'd0, 2'd0);
    chk("t5_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("t5_retire", {31'd0, retire}, 32'd1);
    chk("t5_fault", {31'd0, load_fault}, 32'd1);
    tick();
    tick();
    chk("t5_sticky", {31'd0, load_fault}, 32'd1);

    // 6: async reset during WAIT_LOAD
    drive(1'b1, 4'd4, 1'b1, 1'b1, 3'd2, 2'd0, 32'd0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("t6_wbu_rd", {28'd0, wbu_rd}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    lsu(1'b1, 32'h1234_5678, 2'd0);
    tick();
    lsu(1'b0, 32'd0, 2'd0);
    chk("t6_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("t6_retire", {31'd0, retire}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 4) != 0, 4'($urandom % 16), ($urandom % 4) != 0,
            ($urandom % 2) != 0, 3'($urandom % 8), 2'($urandom % 4), $urandom);
      lsu(($urandom % 3) == 0, $urandom,
          (($urandom % 10) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
